// File: rtl/alu_serial_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | alu_serial_seq: bit-serial add/sub/c1/c2 sequencer built on one adder cell   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module alu_serial_seq #(
    parameter int WIDTH = 5,
    parameter int CNTW  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             ovf_o
);

    localparam logic [1:0]      OP_ADD   = 2'b00;
    localparam logic [1:0]      OP_SUB   = 2'b01;
    localparam logic [1:0]      OP_C1    = 2'b10;
    localparam logic [1:0]      OP_C2    = 2'b11;
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [1:0]       op_q, op_d;
    logic             cy_q, cy_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic             w_sum;
    logic             w_cout;
    logic             w_ovf;

    // Single shared cell; cy_q is carry for add/c2 and borrow for sub.
    always_comb begin
        w_sum  = 1'b0;
        w_cout = 1'b0;
        w_ovf  = 1'b0;
        unique case (op_q)
            OP_ADD: begin
                w_sum  = a_sh_q[0] ^ b_sh_q[0] ^ cy_q;
                w_cout = (a_sh_q[0] & b_sh_q[0]) | (cy_q & (a_sh_q[0] ^ b_sh_q[0]));
                w_ovf  = cy_q ^ w_cout;
            end
            OP_SUB: begin
                w_sum  = a_sh_q[0] ^ b_sh_q[0] ^ cy_q;
                w_cout = (~a_sh_q[0] & b_sh_q[0]) | (cy_q & ~(a_sh_q[0] ^ b_sh_q[0]));
                // On the last bit the shift registers hold the original MSBs.
                w_ovf  = (a_sh_q[0] != b_sh_q[0]) && (w_sum != a_sh_q[0]);
            end
            OP_C1: begin
                w_sum  = ~a_sh_q[0] ^ cy_q;
                w_cout = ~a_sh_q[0] & cy_q;
                w_ovf  = 1'b0;
            end
            OP_C2: begin
                w_sum  = ~a_sh_q[0] ^ cy_q;
                w_cout = ~a_sh_q[0] & cy_q;
                w_ovf  = cy_q ^ w_cout;
            end
            default: begin
                w_sum  = 1'b0;
                w_cout = 1'b0;
                w_ovf  = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        op_d     = op_q;
        cy_d     = cy_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    a_sh_d  = a_i;
                    b_sh_d  = b_i;
                    op_d    = op_i;
                    cnt_d   = '0;
                    cy_d    = (op_i == OP_C2);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                res_sh_d = {w_sum, res_sh_q[WIDTH-1:1]};
                cy_d     = w_cout;
                cnt_d    = cnt_q + CNTW'(1);
                if (cnt_q == LAST_CNT) begin
                    result_d = {w_sum, res_sh_q[WIDTH-1:1]};
                    carry_d  = w_cout;
                    ovf_d    = w_ovf;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            op_q     <= OP_ADD;
            cy_q     <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            op_q     <= op_d;
            cy_q     <= cy_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy_o   = (state_q != ST_IDLE);
    assign done_o   = (state_q == ST_DONE);
    assign result_o = result_q;
    assign carry_o  = carry_q;
    assign ovf_o    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_alu_serial_seq: directed + randomized bench with arithmetic ref model     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_alu_serial_seq;

    localparam int W    = 5;
    localparam int CW   = 3;
    localparam int NSTR = 45;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_i;
    logic [1:0]   op_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] result_o;
    logic         carry_o;
    logic         ovf_o;

    int n_cmp = 0;
    int n_err = 0;

    alu_serial_seq #(.WIDTH(W), .CNTW(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .carry_o  (carry_o),
        .ovf_o    (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference built from plain integer arithmetic on the operand values.
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic c, output logic o);
        int m, ua, ub, sa, sb, s;
        m  = 1 << W;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        case (op)
            2'b00: begin
                r = W'((ua + ub) % m);
                c = (ua + ub) >= m;
                s = sa + sb;
                o = (s < -(m / 2)) || (s > m / 2 - 1);
            end
            2'b01: begin
                r = W'((ua - ub + m) % m);
                c = ua < ub;
                s = sa - sb;
                o = (s < -(m / 2)) || (s > m / 2 - 1);
            end
            2'b10: begin
                r = W'(m - 1 - ua);
                c = 1'b0;
                o = 1'b0;
            end
            default: begin
                r = W'((m - ua) % m);
                c = (ua == 0);
                o = (ua == m / 2);
            end
        endcase
    endfunction

    task automatic scramble();
        op_i = 2'($urandom_range(0, 3));
        a_i  = W'($urandom);
        b_i  = W'($urandom);
    endtask

    // Issue one op from IDLE; optionally poke start during RUN and DONE.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic ec, input logic eo, input bit noisy);
        int lat;
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        @(posedge clk); #1;
        start_i = 1'b0;
        scramble();
        check_val("busy_accept", 32'(busy_o), 32'd1);
        lat = -1;
        for (int n = 1; n <= W + 3; n++) begin
            start_i = noisy && (n == 2 || n == 4);
            scramble();
            @(posedge clk); #1;
            if (done_o) begin
                lat = n;
                break;
            end
            check_val("busy_run", 32'(busy_o), 32'd1);
        end
        start_i = 1'b0;
        check_val("latency", 32'(lat), 32'(W));
        check_val("busy_done", 32'(busy_o), 32'd1);
        check_val("result", 32'(result_o), 32'(er));
        check_val("carry", 32'(carry_o), 32'(ec));
        check_val("ovf", 32'(ovf_o), 32'(eo));
        if (noisy) begin
            start_i = 1'b1;
            scramble();
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        check_val("idle_busy", 32'(busy_o), 32'd0);
        check_val("idle_done", 32'(done_o), 32'd0);
        if (noisy) begin
            @(posedge clk); #1;
            check_val("no_queue_busy", 32'(busy_o), 32'd0);
            check_val("held_result", 32'(result_o), 32'(er));
        end
    endtask

    task automatic run_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit noisy);
        logic [W-1:0] r;
        logic c, o;
        model(op, a, b, r, c, o);
        run_op(op, a, b, r, c, o, noisy);
    endtask

    logic [1:0]   op_h [NSTR];
    logic [W-1:0] a_h  [NSTR];
    logic [W-1:0] b_h  [NSTR];

    initial begin
        logic [W-1:0] r;
        logic c, o;
        int last_done, n_done, idx, seen;

        reset   = 1'b1;
        start_i = 1'b0;
        op_i    = 2'b00;
        a_i     = '0;
        b_i     = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_val("rst_busy", 32'(busy_o), 32'd0);
        check_val("rst_done", 32'(done_o), 32'd0);
        check_val("rst_result", 32'(result_o), 32'd0);
        check_val("rst_carry", 32'(carry_o), 32'd0);
        check_val("rst_ovf", 32'(ovf_o), 32'd0);

        // Directed vectors with hand-computed expectations.
        run_op(2'b00, 5'b01011, 5'b00110, 5'b10001, 1'b0, 1'b1, 1'b0);
        run_op(2'b00, 5'b11111, 5'b00001, 5'b00000, 1'b1, 1'b0, 1'b0);
        run_op(2'b01, 5'b00011, 5'b00101, 5'b11110, 1'b1, 1'b0, 1'b0);
        run_op(2'b01, 5'b10000, 5'b00001, 5'b01111, 1'b0, 1'b1, 1'b0);
        run_op(2'b10, 5'b10101, 5'b11011, 5'b01010, 1'b0, 1'b0, 1'b0);
        run_op(2'b11, 5'b00110, 5'b10101, 5'b11010, 1'b0, 1'b0, 1'b0);
        run_op(2'b11, 5'b00000, 5'b11111, 5'b00000, 1'b1, 1'b0, 1'b0);
        run_op(2'b11, 5'b10000, 5'b00000, 5'b10000, 1'b0, 1'b1, 1'b0);

        // Reset in the third RUN cycle abandons the op.
        start_i = 1'b1;
        op_i    = 2'b00;
        a_i     = 5'b01111;
        b_i     = 5'b00111;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_val("abort_busy", 32'(busy_o), 32'd0);
        check_val("abort_result", 32'(result_o), 32'd0);
        check_val("abort_carry", 32'(carry_o), 32'd0);
        check_val("abort_ovf", 32'(ovf_o), 32'd0);
        seen = 0;
        repeat (W + 3) begin
            @(posedge clk); #1;
            if (done_o || busy_o) seen++;
        end
        check_val("abort_no_done", 32'(seen), 32'd0);
        run_op(2'b00, 5'b00001, 5'b00001, 5'b00010, 1'b0, 1'b0, 1'b0);

        // Start poked during RUN and DONE must be ignored.
        run_model(2'b01, 5'b01010, 5'b10011, 1'b1);
        run_model(2'b00, 5'b10110, 5'b11001, 1'b1);

        // Randomized single ops against the model.
        for (int i = 0; i < 30; i++) begin
            run_model(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), bit'($urandom_range(0, 1)));
        end

        // Start held high with inputs changing every cycle.
        last_done = -1;
        n_done    = 0;
        for (int t = 0; t < NSTR; t++) begin
            if (t > 0) begin
                @(posedge clk); #1;
                if (done_o) begin
                    n_done++;
                    if (last_done < 0) check_val("stream_first", 32'(t), 32'(W + 1));
                    else               check_val("stream_gap", 32'(t - last_done), 32'(W + 2));
                    last_done = t;
                    idx = t - (W + 1);
                    if (idx < 0) begin
                        check_val("stream_idx", 32'(idx), 32'd0);
                    end else begin
                        model(op_h[idx], a_h[idx], b_h[idx], r, c, o);
                        check_val("stream_result", 32'(result_o), 32'(r));
                        check_val("stream_carry", 32'(carry_o), 32'(c));
                        check_val("stream_ovf", 32'(ovf_o), 32'(o));
                    end
                end
            end
            start_i = 1'b1;
            scramble();
            op_h[t] = op_i;
            a_h[t]  = a_i;
            b_h[t]  = b_i;
        end
        start_i = 1'b0;
        check_val("stream_count", 32'(n_done), 32'((NSTR - 1 - (W + 1)) / (W + 2) + 1));
        repeat (2 * W + 4) @(posedge clk);
        #1;
        check_val("drain_idle", 32'(busy_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
- Multi-cycle sequencer that runs the ALU operations one bit per clock through a single full-adder/full-subtractor cell.
- Operations: add, subtract, one's complement, two's complement.
- Replaces the rippled WIDTH-cell arrays where area matters.
- Sits between a requester (test harness or future control unit) and the register file; start/busy/done handshake, operands latched on accept.

Parameters:
- WIDTH, 5, operand/result width in bits (minimum 2).
- CNTW, 3, bit-counter width; must satisfy 2^CNTW >= WIDTH.

Ports:
- clk, input, 1, single clock, all state updates on rising edge.
- reset, input, 1, synchronous active-high reset, sampled on rising edge of clk.
- start, input, 1, request; accepted only when state is IDLE.
- op, input, 2, 00 add (a+b), 01 sub (a-b), 10 c1 (~a), 11 c2 (~a+1); latched on accept.
- a, input, WIDTH, operand A; latched on accept.
- b, input, WIDTH, operand B; latched on accept, ignored for op 10/11.
- busy, output, 1, high in RUN and DONE.
- done, output, 1, one-cycle pulse in DONE; result/carry/ovf valid from this cycle.
- result, output, WIDTH, last completed result; held until next completion.
- carry, output, 1, add: carry-out; sub: borrow-out (1 iff a<b unsigned); c1: 0; c2: carry-out of ~a+1.
- ovf, output, 1, add/sub: signed two's-complement overflow; c1: 0; c2: 1 iff a = 1 followed by WIDTH-1 zeros.

Behaviour:
- Reset: state IDLE, busy=0, done=0, result=0, carry=0, ovf=0, bit counter=0, internal shift regs and carry flop=0. Reset has priority over every other event, including mid-RUN (operation abandoned, no done pulse).
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge k latches a, b, op; counter<=0; carry flop<=1 for op 11, else 0; state<=RUN. start=0 stays IDLE.
- RUN: one bit per cycle, LSB first.
  - Bit i = a_sh[0] combined with b_sh[0] (add/sub), or ~a_sh[0] (c1/c2), plus the carry/borrow flop.
  - Sum bit shifts into the internal result register at MSB; a_sh/b_sh shift right.
  - Counter increments; after the cycle with counter==WIDTH-1, state<=DONE and outputs load.
  - start is ignored.
- Output load at RUN->DONE:
  - result <= assembled value; carry <= final carry/borrow flop value.
  - ovf per op: add = carry into MSB XOR carry out of MSB; sub = (a_msb != b_msb) && (res_msb != a_msb); c2 per port rule.
- DONE: done=1, busy=1 for exactly one cycle; state<=IDLE. start in DONE is ignored (not queued).
- Latency: start accepted at edge k, RUN occupies cycles k+1..k+WIDTH, done high in cycle k+WIDTH+1. Minimum start-to-start spacing is WIDTH+2 cycles.
- Stability: result/carry/ovf change only at RUN->DONE or reset. Changes to a/b/op inputs after accept have no effect.
- Arithmetic: modulo 2^WIDTH, unsigned carry/borrow semantics as above. No X propagation from b for c1/c2.

Test Plan (WIDTH=5):
1. Reset, then add a=01011 b=00110 with start pulse at edge k -> done only in cycle k+6; result=10001, carry=0, ovf=1; busy high cycles k+1..k+6.
2. add a=11111 b=00001 -> result=00000, carry=1, ovf=0. sub a=00011 b=00101 -> result=11110, carry(borrow)=1, ovf=0. sub a=10000 b=00001 -> result=01111, carry=0, ovf=1.
3. c1 a=10101 -> result=01010, carry=0, ovf=0. c2 a=00110 -> result=11010, carry=0, ovf=0. c2 a=00000 -> result=00000, carry=1, ovf=0. c2 a=10000 -> result=10000, ovf=1.
4. Start held high continuously with changing a/b/op -> accepts only in IDLE cycles; each op completes on its latched operands; done pulses exactly WIDTH+2 cycles apart.
5. Reset asserted during 3rd RUN cycle -> next cycle IDLE, busy=0, result=carry=ovf=0; no done pulse. The following add 00001+00001 yields result=00010.
6. Start re-asserted during RUN and during DONE with different operands -> ignored. Result of the in-flight op is unchanged and no extra done pulse occurs.
